// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, register-index width and the x0 register-match helper.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

    // A destination register of x0 never produces a dependency.
    function automatic logic reg_hit(input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs1,
                                     input logic [REG_W-1:0] rs2);
        return (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational dependency detection between decode sources and
// in-flight destinations: load-use (lu) and decode-branch (bh) hazards.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic             BranchD,
    input  logic [REG_W-1:0] RdE,
    input  logic             RegWriteEnE,
    input  logic             MemReadEnE,
    input  logic [REG_W-1:0] RdM,
    input  logic             MemReadEnM,
    output logic             lu,
    output logic             bh
);

    logic hit_e;
    logic hit_m;

    always_comb begin
        hit_e = reg_hit(RdE, Rs1D, Rs2D);
        hit_m = reg_hit(RdM, Rs1D, Rs2D);
        lu    = MemReadEnE & hit_e;
        // Branches resolve in decode, so they also wait on ALU results in E and loads in M.
        bh    = BranchD & ((RegWriteEnE & hit_e) | (MemReadEnM & hit_m));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: stall/flush generation, data-memory wait with timeout,
// halt drain, and a saturating count of fetch-stall cycles.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic             BranchD,
    input  logic [REG_W-1:0] RdE,
    input  logic             RegWriteEnE,
    input  logic             MemReadEnE,
    input  logic [REG_W-1:0] RdM,
    input  logic             MemReadEnM,
    input  logic             PCSF,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic lu;
    logic bh;
    logic mw;
    logic run_stall;

    hazard_detect u_hazard_detect (
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .BranchD     (BranchD),
        .RdE         (RdE),
        .RegWriteEnE (RegWriteEnE),
        .MemReadEnE  (MemReadEnE),
        .RdM         (RdM),
        .MemReadEnM  (MemReadEnM),
        .lu          (lu),
        .bh          (bh)
    );

    assign mw        = mem_req & ~mem_ready;
    // A redirect discards the dependent instruction, so it wins over lu/bh.
    assign run_stall = (lu | bh) & ~PCSF;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        drain_cnt_d = drain_cnt_q;
        mem_err_d   = mem_err_q;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;

        case (state_q)
            ST_RUN: begin
                wait_cnt_d  = '0;
                drain_cnt_d = '0;
                if (mw) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                    StallF     = 1'b1;
                    StallD     = 1'b1;
                    StallE     = 1'b1;
                end else begin
                    FlushD = PCSF;
                    StallF = run_stall;
                    StallD = run_stall;
                    FlushE = run_stall;
                    if (halt_req) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    // Completion cycle behaves like RUN so a held redirect lands now.
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                    FlushD     = PCSF;
                    StallF     = run_stall;
                    StallD     = run_stall;
                    FlushE     = run_stall;
                end else begin
                    StallF     = 1'b1;
                    StallD     = 1'b1;
                    StallE     = 1'b1;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    if (wait_cnt_q >= WAIT_W'(MEM_TIMEOUT - 1)) begin
                        mem_err_d = 1'b1;
                        state_d   = ST_HALTED;
                    end
                end
            end
            ST_DRAIN: begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
                if (mw) begin
                    StallE = 1'b1;
                end else if (drain_cnt_q == DRN_W'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRN_W'(1);
                end
            end
            ST_HALTED: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushE = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (!rst) begin
            StallF = 1'b0;
            StallD = 1'b0;
            StallE = 1'b0;
            FlushD = 1'b0;
            FlushE = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            drain_cnt_q <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign halted    = (state_q == ST_HALTED);
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: the driver queues expected outputs
// per cycle, a monitor on the falling edge pops and compares them.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, RdE, RdM;
    logic        BranchD, RegWriteEnE, MemReadEnE, MemReadEnM;
    logic        PCSF, mem_req, mem_ready, halt_req;
    logic        StallF, StallD, StallE, FlushD, FlushE, halted, mem_err;
    logic [31:0] stall_cnt;

    typedef struct {
        string       tag;
        logic [6:0]  ctrl;   // {StallF,StallD,StallE,FlushD,FlushE,halted,mem_err}
        logic [6:0]  mask;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [6:0] ALL  = 7'b1111111;
    localparam logic [6:0] NOHM = 7'b1111100;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT  (16),
        .DRAIN_CYCLES (4),
        .CNT_W        (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .BranchD     (BranchD),
        .RdE         (RdE),
        .RegWriteEnE (RegWriteEnE),
        .MemReadEnE  (MemReadEnE),
        .RdM         (RdM),
        .MemReadEnM  (MemReadEnM),
        .PCSF        (PCSF),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .halt_req    (halt_req),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .halted      (halted),
        .mem_err     (mem_err),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        Rs1D = 5'd0; Rs2D = 5'd0; RdE = 5'd0; RdM = 5'd0;
        BranchD = 1'b0; RegWriteEnE = 1'b0; MemReadEnE = 1'b0; MemReadEnM = 1'b0;
        PCSF = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [6:0] ctrl,
                       input logic [6:0] mask, input int cnt);
        exp_t e;
        e.tag  = tag;
        e.ctrl = ctrl;
        e.mask = mask;
        e.cnt  = 32'(cnt);
        exp_q.push_back(e);
    endtask

    // Monitor: compares the cycle's outputs mid-cycle against the queued expectation.
    initial begin
        exp_t       e;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {StallF, StallD, StallE, FlushD, FlushE, halted, mem_err};
                n_cmp++;
                if ((got & e.mask) !== (e.ctrl & e.mask)) begin
                    n_bad++;
                    $display("FAIL %s ctrl got=%b want=%b (mask %b)", e.tag, got, e.ctrl, e.mask);
                end
                n_cmp++;
                if (stall_cnt !== e.cnt) begin
                    n_bad++;
                    $display("FAIL %s stall_cnt got=%0d want=%0d", e.tag, stall_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        rst = 1'b0;
        MemReadEnE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; halt_req = 1'b1;

        // Reset cycle: hazard and halt inputs present but outputs forced low
        tick(); chk("reset", 7'b0000000, ALL, 0);
        tick(); rst = 1'b1; clr(); chk("idle", 7'b0000000, ALL, 0);

        // Load-use on x5, then consumer proceeds
        tick(); clr(); MemReadEnE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; chk("lu_x5", 7'b1100100, ALL, 0);
        tick(); clr(); chk("lu_done", 7'b0000000, ALL, 1);
        tick(); clr(); MemReadEnE = 1'b1; RdE = 5'd0; Rs1D = 5'd0; chk("lu_x0", 7'b0000000, ALL, 1);

        // Decode branch hazards: ALU result in E, then load in M
        tick(); clr(); BranchD = 1'b1; RegWriteEnE = 1'b1; RdE = 5'd6; Rs1D = 5'd6; chk("bh_e", 7'b1100100, ALL, 1);
        tick(); clr(); BranchD = 1'b1; MemReadEnM = 1'b1; RdM = 5'd6; Rs2D = 5'd6; chk("bh_m", 7'b1100100, ALL, 2);
        tick(); clr(); BranchD = 1'b1; RdE = 5'd6; Rs1D = 5'd6; chk("bh_nowr", 7'b0000000, ALL, 3);

        // Redirect overrides load-use
        tick(); clr(); PCSF = 1'b1; MemReadEnE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; chk("pcsf_lu", 7'b0001000, ALL, 3);

        // Memory wait with a pending redirect, three ready-low cycles
        tick(); clr(); mem_req = 1'b1; PCSF = 1'b1; chk("mw1", 7'b1110000, ALL, 3);
        tick(); clr(); mem_req = 1'b1; PCSF = 1'b1; halt_req = 1'b1; chk("mw2", 7'b1110000, ALL, 4);
        tick(); clr(); mem_req = 1'b1; PCSF = 1'b1; MemReadEnE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
        chk("mw3", 7'b1110000, ALL, 5);
        tick(); clr(); mem_req = 1'b1; mem_ready = 1'b1; PCSF = 1'b1; chk("mw_done", 7'b0001000, ALL, 6);
        tick(); clr(); chk("after_mw", 7'b0000000, ALL, 6);

        // Timeout: 16 consecutive ready-low cycles
        tick(); clr(); mem_req = 1'b1; chk("to_start", 7'b1110000, ALL, 6);
        for (int i = 0; i < 15; i++) begin
            tick(); clr(); mem_req = 1'b1; chk("to_wait", 7'b1110000, ALL, 7 + i);
        end
        tick(); clr(); chk("to_halt", 7'b1110111, ALL, 22);
        tick(); clr(); mem_req = 1'b1; mem_ready = 1'b1; PCSF = 1'b1; chk("to_hold1", 7'b1110111, ALL, 23);
        tick(); clr(); halt_req = 1'b1; chk("to_hold2", 7'b1110111, ALL, 24);
        tick(); clr(); rst = 1'b0; chk("to_rst", 7'b0000000, NOHM, 25);

        // Halt drain, with one frozen cycle from a memory wait
        tick(); clr(); rst = 1'b1; halt_req = 1'b1; chk("halt_req", 7'b0000000, ALL, 0);
        tick(); clr(); chk("drain1", 7'b1100100, ALL, 0);
        tick(); clr(); mem_req = 1'b1; chk("drain_mw", 7'b1110100, ALL, 1);
        tick(); clr(); chk("drain2", 7'b1100100, ALL, 2);
        tick(); clr(); chk("drain3", 7'b1100100, ALL, 3);
        tick(); clr(); chk("drain4", 7'b1100100, ALL, 4);
        tick(); clr(); chk("drain_halt", 7'b1110110, ALL, 5);
        tick(); clr(); rst = 1'b0; chk("halt_rst", 7'b0000000, NOHM, 6);

        // Reset in the middle of a drain
        tick(); clr(); rst = 1'b1; halt_req = 1'b1; chk("halt_req2", 7'b0000000, ALL, 0);
        tick(); clr(); chk("d2_c1", 7'b1100100, ALL, 0);
        tick(); clr(); rst = 1'b0; chk("d2_rst", 7'b0000000, ALL, 1);
        tick(); clr(); rst = 1'b1; chk("d2_run", 7'b0000000, ALL, 0);
        tick(); clr(); MemReadEnE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; chk("d2_lu", 7'b1100100, ALL, 0);
        tick(); clr(); chk("d2_end", 7'b0000000, ALL, 1);

        tick();
        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_queue left=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
